// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard control unit.
//   state_t     : 2-bit FSM state (RUN=0, MEM_WAIT=1, FETCH_WAIT=2)
//   ctrl_t      : pipeline control bundle driven by the unit
//   FREEZE      : hold PC, IF/ID and the back end (memory wait / illegal state)
//   NORMAL      : advance the whole pipeline
//   RESET_CTRL  : control values forced while reset is asserted
//   LOAD_USE    : hold PC and IF/ID, inject a bubble into ID/EX
//   REDIRECT    : advance PC, squash IF/ID (taken branch or split fetch)
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    FETCH_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_stall;
  } ctrl_t;

  localparam ctrl_t FREEZE     = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                   idex_bubble: 1'b0, pipe_stall: 1'b1};
  localparam ctrl_t NORMAL     = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                   idex_bubble: 1'b0, pipe_stall: 1'b0};
  localparam ctrl_t RESET_CTRL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                   idex_bubble: 1'b1, pipe_stall: 1'b0};
  localparam ctrl_t LOAD_USE   = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                   idex_bubble: 1'b1, pipe_stall: 1'b0};
  localparam ctrl_t REDIRECT   = '{pc_write: 1'b1, ifid_write: 1'b0, ifid_flush: 1'b1,
                                   idex_bubble: 1'b0, pipe_stall: 1'b0};

endpackage

// File: rtl/hazard_perf_counters.sv
// Three saturating event counters for the hazard control unit.
//   clk, rst            : clock, synchronous active-high clear
//   lu_evt              : load-use bubble this cycle
//   stall_evt           : back-end freeze this cycle
//   flush_evt           : IF/ID flush from branch or split fetch this cycle
//   lu_cnt/stall_cnt/flush_cnt : CNT_W-bit counts, stick at all-ones
module hazard_perf_counters #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lu_evt,
  input  logic             stall_evt,
  input  logic             flush_evt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (lu_evt && (lu_cnt != '1))       lu_cnt    <= lu_cnt + 1'b1;
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush side of the pipeline hazard logic: load-use stalls, data-memory
// waits, split fetches of straddling 32-bit instructions and taken-branch flush.
//   clk_i, rst_i             : clock, synchronous active-high reset
//   RS1/RS2addr_IFID_i       : source registers of the instruction in ID
//   RDaddr_IDEX_i, MemRead_IDEX_i : destination / load flag of the instruction in EX
//   Branch_taken_i, FetchSplit_i  : redirect and split-fetch requests
//   MemReq_i, MemAck_i       : data-memory access in MEM and its completion
//   PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, PipeStall_o : pipeline controls
//   State_o                  : RUN=0, MEM_WAIT=1, FETCH_WAIT=2
// Optional macro HCU_PERF_CNT_EN adds LoadUseCnt_o, MemWaitCnt_o, FlushCnt_o.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] RS1addr_IFID_i,
  input  logic [ADDR_W-1:0] RS2addr_IFID_i,
  input  logic [ADDR_W-1:0] RDaddr_IDEX_i,
  input  logic              MemRead_IDEX_i,
  input  logic              Branch_taken_i,
  input  logic              FetchSplit_i,
  input  logic              MemReq_i,
  input  logic              MemAck_i,
  output logic              PCWrite_o,
  output logic              IFIDWrite_o,
  output logic              IFIDFlush_o,
  output logic              IDEXBubble_o,
  output logic              PipeStall_o,
  output logic [1:0]        State_o
`ifdef HCU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  LoadUseCnt_o,
  output logic [CNT_W-1:0]  MemWaitCnt_o,
  output logic [CNT_W-1:0]  FlushCnt_o
`endif
);

  state_t state_q, state_d;
  state_t ret_q, ret_d;
  ctrl_t  ctrl;
  logic   lu, mw;
  logic   eval, split_ok;

  assign lu = MemRead_IDEX_i && (RDaddr_IDEX_i != '0) &&
              ((RDaddr_IDEX_i == RS1addr_IFID_i) || (RDaddr_IDEX_i == RS2addr_IFID_i));
  assign mw = MemReq_i && !MemAck_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      ret_q   <= RUN;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  // RUN, FETCH_WAIT and an acknowledged MEM_WAIT share one priority chain;
  // split_ok distinguishes the RUN rule set from the FETCH_WAIT one.
  always_comb begin
    ctrl     = FREEZE;
    state_d  = RUN;
    ret_d    = ret_q;
    eval     = 1'b0;
    split_ok = 1'b0;
    case (state_q)
      RUN: begin
        eval     = 1'b1;
        split_ok = 1'b1;
      end
      MEM_WAIT: begin
        if (MemAck_i) begin
          eval     = 1'b1;
          split_ok = (ret_q == RUN);
        end else begin
          state_d = MEM_WAIT;
        end
      end
      FETCH_WAIT: begin
        eval = 1'b1;
      end
      default: ;
    endcase
    if (eval) begin
      if (mw) begin
        ctrl    = FREEZE;
        ret_d   = (state_q == FETCH_WAIT) ? FETCH_WAIT : RUN;
        state_d = MEM_WAIT;
      end else if (lu) begin
        ctrl = LOAD_USE;
      end else if (Branch_taken_i) begin
        ctrl = REDIRECT;
      end else if (split_ok && FetchSplit_i) begin
        ctrl    = REDIRECT;
        state_d = FETCH_WAIT;
      end else begin
        ctrl = NORMAL;
      end
    end
    if (rst_i) begin
      ctrl = RESET_CTRL;
    end
  end

  assign PCWrite_o    = ctrl.pc_write;
  assign IFIDWrite_o  = ctrl.ifid_write;
  assign IFIDFlush_o  = ctrl.ifid_flush;
  assign IDEXBubble_o = ctrl.idex_bubble;
  assign PipeStall_o  = ctrl.pipe_stall;
  assign State_o      = rst_i ? RUN : state_q;

`ifdef HCU_PERF_CNT_EN
  // Outside reset, a bubble only comes from load-use and a flush only from
  // a branch or split fetch, so the output bits identify the events.
  hazard_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk       (clk_i),
    .rst       (rst_i),
    .lu_evt    (ctrl.idex_bubble & ~rst_i),
    .stall_evt (ctrl.pipe_stall),
    .flush_evt (ctrl.ifid_flush & ~rst_i),
    .lu_cnt    (LoadUseCnt_o),
    .stall_cnt (MemWaitCnt_o),
    .flush_cnt (FlushCnt_o)
  );
`else
  // CNT_W only sizes the counter ports; keep it elaborated in this build.
  if (CNT_W == 0) begin : g_cnt_w_ref
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

  localparam int CW = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       ld, br, sp, req, ack;
  logic       pcw, ifw, flu, bub, stl;
  logic [1:0] st;
`ifdef HCU_PERF_CNT_EN
  logic [CW-1:0] lu_cnt, mw_cnt, fl_cnt;
`endif

  always #5 clk = ~clk;

  hazard_control_unit #(.ADDR_W(5), .CNT_W(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .RS1addr_IFID_i (rs1),
    .RS2addr_IFID_i (rs2),
    .RDaddr_IDEX_i  (rd),
    .MemRead_IDEX_i (ld),
    .Branch_taken_i (br),
    .FetchSplit_i   (sp),
    .MemReq_i       (req),
    .MemAck_i       (ack),
    .PCWrite_o      (pcw),
    .IFIDWrite_o    (ifw),
    .IFIDFlush_o    (flu),
    .IDEXBubble_o   (bub),
    .PipeStall_o    (stl),
    .State_o        (st)
`ifdef HCU_PERF_CNT_EN
    ,
    .LoadUseCnt_o   (lu_cnt),
    .MemWaitCnt_o   (mw_cnt),
    .FlushCnt_o     (fl_cnt)
`endif
  );

  // Reference model: pick one pipeline action per cycle, then map it to controls.
  localparam int A_RESET = 0, A_FREEZE = 1, A_BUBBLE = 2, A_REDIRECT = 3, A_ADVANCE = 4;

  int m_state = 0;     // 0 RUN, 1 MEM_WAIT, 2 FETCH_WAIT
  int m_ret   = 0;     // rule set to resume with after a memory wait
  longint m_lu = 0, m_mw = 0, m_fl = 0;

  int vectors = 0;
  int miscompares = 0;

  function automatic void model(output int act, output int nxt, output int nret);
    bit hz_lu, hz_mw;
    int mode;
    hz_lu = ld && (rd != 0) && ((rd == rs1) || (rd == rs2));
    hz_mw = req && !ack;
    nret = m_ret;
    nxt  = 0;
    if (rst) begin
      act = A_RESET; nret = 0;
    end else if (m_state == 1 && !ack) begin
      act = A_FREEZE; nxt = 1;
    end else begin
      mode = (m_state == 1) ? m_ret : m_state;
      if (hz_mw)                  begin act = A_FREEZE; nxt = 1; nret = mode; end
      else if (hz_lu)             act = A_BUBBLE;
      else if (br)                act = A_REDIRECT;
      else if (sp && mode == 0)   begin act = A_REDIRECT; nxt = 2; end
      else                        act = A_ADVANCE;
    end
  endfunction

  function automatic logic [4:0] ctrl_of(int act);
    // {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeStall}
    case (act)
      A_RESET:    return 5'b00110;
      A_FREEZE:   return 5'b00001;
      A_BUBBLE:   return 5'b00010;
      A_REDIRECT: return 5'b10100;
      default:    return 5'b11000;
    endcase
  endfunction

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                       input logic l, input logic b, input logic s,
                       input logic q, input logic k, input logic r);
    rs1 = a1; rs2 = a2; rd = d; ld = l; br = b; sp = s; req = q; ack = k; rst = r;
  endtask

  task automatic step(input string tag);
    int act, nxt, nret;
    logic [6:0] exp_v, obs_v;
    #3;
    model(act, nxt, nret);
    exp_v = {ctrl_of(act), (rst ? 2'd0 : 2'(m_state))};
    obs_v = {pcw, ifw, flu, bub, stl, st};
    vectors++;
    assert (obs_v === exp_v) else begin
      miscompares++;
      $error("FAIL %s: {pcw,ifw,flush,bubble,stall,state} got %b expected %b", tag, obs_v, exp_v);
    end
`ifdef HCU_PERF_CNT_EN
    vectors++;
    assert ({lu_cnt, mw_cnt, fl_cnt} === {m_lu[CW-1:0], m_mw[CW-1:0], m_fl[CW-1:0]}) else begin
      miscompares++;
      $error("FAIL %s_cnt: got %0d/%0d/%0d expected %0d/%0d/%0d", tag,
             lu_cnt, mw_cnt, fl_cnt, m_lu, m_mw, m_fl);
    end
`endif
    @(posedge clk);
    if (act == A_RESET) begin
      m_lu = 0; m_mw = 0; m_fl = 0;
    end else begin
      if (act == A_BUBBLE)   m_lu++;
      if (act == A_FREEZE)   m_mw++;
      if (act == A_REDIRECT) m_fl++;
    end
    m_state = nxt;
    m_ret   = nret;
    #1;
  endtask

  task automatic idle(input string tag);
    drive(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(tag);
  endtask

  initial begin
    // reset
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("reset0");
    step("reset1");
    idle("post_reset");

    // load-use, then same with rd=0
    drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("load_use");
    drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("load_use_rd0");

    // memory wait: three unacked cycles then ack
    for (int i = 0; i < 3; i++) begin
      drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step("mem_wait");
    end
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("mem_ack");
    idle("mem_after");

    // split fetch held two cycles
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("split1");
    step("split2_ignored");
    idle("split_after");

    // priority: load-use over branch, branch cancels split
    drive(5'd7, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lu_over_branch");
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("branch_cancels_split");
    idle("prio_after");

    // memory wait raised in FETCH_WAIT, ack after two wait cycles
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("fw_enter");
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("fw_mw");
    step("fw_mw_wait");
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step("fw_ack_no_split");
    idle("fw_after");

    // reset in the middle of a memory wait
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("pre_rst_mw");
    drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("rst_mid_mw");
    idle("rst_after");

    // randomized traffic; small register range makes load-use frequent
    for (int n = 0; n < 3000; n++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Producer/stall side of the pipeline hazard logic; the forwarding path handles RAW cases that bypass can resolve.
- Resolves the cases forwarding cannot:
  - load-use stalls,
  - multi-cycle data-memory waits,
  - split fetches of 32-bit instructions straddling a halfword boundary (compressed-ISA fetch),
  - taken-branch flush.
- Sits beside the ID stage and drives the PC, IF/ID and ID/EX write/flush controls.

Parameters:
ADDR_W, 5, register address width
CNT_W, 32, width of each performance counter (used only with HCU_PERF_CNT_EN)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
RS1addr_IFID_i  in  ADDR_W  rs1 of the instruction in ID
RS2addr_IFID_i  in  ADDR_W  rs2 of the instruction in ID
RDaddr_IDEX_i  in  ADDR_W  rd of the instruction in EX
MemRead_IDEX_i  in  1  instruction in EX is a load
Branch_taken_i  in  1  branch resolved taken in ID this cycle
FetchSplit_i  in  1  fetch unit needs a second cycle to complete a straddling 32-bit instruction
MemReq_i  in  1  load/store active in MEM this cycle
MemAck_i  in  1  data memory completes the MEM access this cycle
PCWrite_o  out  1  PC update enable
IFIDWrite_o  out  1  IF/ID update enable
IFIDFlush_o  out  1  load NOP into IF/ID
IDEXBubble_o  out  1  zero the ID/EX control fields
PipeStall_o  out  1  freeze the EX/MEM and MEM/WB registers
State_o  out  2  FSM state: RUN=0, MEM_WAIT=1, FETCH_WAIT=2

Behaviour:
Reset:
- While rst_i=1: state<=RUN, ret_state<=RUN.
- Reset outputs are forced: PCWrite_o=0, IFIDWrite_o=0, IFIDFlush_o=1, IDEXBubble_o=1, PipeStall_o=0, State_o=RUN.
- A reset asserted mid-MEM_WAIT or mid-FETCH_WAIT abandons that state on the next edge.

Outputs:
- All outputs are combinational from the registered state plus the current inputs.
- Output latency is 0 cycles; state transitions take effect at the next edge.

Hazard terms:
- lu = MemRead_IDEX_i & (RDaddr_IDEX_i!=0) & ((RDaddr_IDEX_i==RS1addr_IFID_i)|(RDaddr_IDEX_i==RS2addr_IFID_i))
- mw = MemReq_i & ~MemAck_i

Evaluation order in RUN, and in MEM_WAIT when MemAck_i=1 (first match wins):
1. mw: freeze, i.e. PipeStall_o=1, PCWrite_o=0, IFIDWrite_o=0, IFIDFlush_o=0, IDEXBubble_o=0. ret_state<=RUN; next MEM_WAIT.
2. lu: PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1. Branch_taken_i and FetchSplit_i are ignored; the instruction re-presents next cycle. Stay RUN.
3. Branch_taken_i: IFIDFlush_o=1, PCWrite_o=1. A simultaneous FetchSplit_i is cancelled because the redirect aborts that fetch. Stay RUN.
4. FetchSplit_i: PCWrite_o=1, IFIDFlush_o=1. Next FETCH_WAIT.
5. Otherwise: PCWrite_o=1, IFIDWrite_o=1, all others 0.

MEM_WAIT:
- MemAck_i=0: freeze outputs; stay.
- MemAck_i=1: PipeStall_o=0. Evaluate per ret_state (RUN rules, or FETCH_WAIT rules); next state from that evaluation.

FETCH_WAIT (exactly one cycle):
- FetchSplit_i is ignored in this state.
- If mw: freeze, ret_state<=FETCH_WAIT, next MEM_WAIT.
- Else outputs are RUN rules 2, 3, 5; next RUN.

State_o=3 is unreachable. Any illegal state recovers to RUN on the next edge with freeze outputs.

Optional Feature:
- HCU_PERF_CNT_EN defined:
  - Adds outputs LoadUseCnt_o, MemWaitCnt_o and FlushCnt_o, each CNT_W bits.
  - Each counter increments on every cycle in which IDEXBubble_o from lu, PipeStall_o, or IFIDFlush_o from branch/split respectively is 1.
  - Counters saturate at all-ones and clear on rst_i.
- Undefined: the ports and logic are absent; the core behaviour is identical.

Decomposition:
- Shared package hazard_pkg holds:
  - state encoding constants RUN/MEM_WAIT/FETCH_WAIT,
  - the 2-bit state typedef,
  - the output-bundle constants FREEZE, NORMAL and RESET_CTRL.
- One sub-module, hazard_perf_counters (three saturating counters), instantiated only under HCU_PERF_CNT_EN.

Test Plan:
1. Load-use:
   - Stimulus: MemRead_IDEX_i=1, RDaddr_IDEX_i=5, RS2addr_IFID_i=5 for one cycle.
   - Response: PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1. With rd=0 instead: normal, PCWrite_o=1.
2. Memory wait:
   - Stimulus: MemReq_i=1 with MemAck_i low for 3 cycles, then high.
   - Response: PipeStall_o=1 for exactly 3 cycles, State_o=1. Ack cycle: PipeStall_o=0, PCWrite_o=1. State_o=0 after.
3. Split fetch:
   - Stimulus: FetchSplit_i held high for 2 cycles.
   - Response: cycle 1 IFIDFlush_o=1, PCWrite_o=1, next State_o=2. Cycle 2 FetchSplit_i ignored, IFIDWrite_o=1, return to RUN.
4. Priority:
   - Stimulus: lu and Branch_taken_i both high in the same cycle.
   - Response: IDEXBubble_o=1, IFIDFlush_o=0. Branch_taken_i and FetchSplit_i together: flush, State_o stays 0.
5. Memory wait from FETCH_WAIT:
   - Stimulus: mw raised while in FETCH_WAIT; ack after 2 cycles.
   - Response: State_o 2→1→1→2 semantics. Ack cycle evaluates FETCH_WAIT rules, then RUN.
6. Reset mid-operation:
   - Stimulus: rst_i pulsed during MEM_WAIT.
   - Response: IFIDFlush_o=1, IDEXBubble_o=1, PCWrite_o=0 while rst_i is high; State_o=0 next cycle. With HCU_PERF_CNT_EN, all counters are 0.
